// File: rtl/xdom_ddr3_pg_requester_if.sv
// Page-transfer handshake bundle between the xdom requester and the DDR3 page mux.
// Latency: none, wires only.
// Backpressure: 4-phase req/ack; pg_ack arrives from the DDR3 ui clock domain.
interface xdom_ddr3_pg_requester_if #(
  parameter int unsigned ADDR_W = 28
);
  logic              pg_req;
  logic              pg_optype;
  logic [ADDR_W-1:0] pg_req_addr;
  logic              pg_ack;

  modport master (
    output pg_req,
    output pg_optype,
    output pg_req_addr,
    input  pg_ack
  );

  modport slave (
    input  pg_req,
    input  pg_optype,
    input  pg_req_addr,
    output pg_ack
  );
endinterface

// File: rtl/xdom_ddr3_pg_requester.sv
// Sequences a multi-page DDR3 transfer as one 4-phase req/ack handshake per page.
// Latency: start -> WAIT_GO next cycle; go seen -> pg_req next cycle; ack -> 2-flop sync.
// Backpressure: each page waits for buf_go, then for the mux ack; a slow ack only flags timeout.
module xdom_ddr3_pg_requester #(
  parameter int unsigned       ADDR_W    = 28,
  parameter logic [ADDR_W-1:0] PG_STRIDE = ADDR_W'(32'h400),
  parameter int unsigned       NPG_W     = 8,
  parameter int unsigned       TO_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic                  cmd_optype,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [NPG_W-1:0]      cmd_npages,
  input  logic                  cmd_abort,
  input  logic                  buf_go,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_timeout,
  output logic                  pg_done,
  output logic [NPG_W-1:0]      pages_done,
  xdom_ddr3_pg_requester_if.master pg_if
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_GO = 3'd1,
    REQ     = 3'd2,
    ACKLOW  = 3'd3,
    FIN     = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = '1;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               err_timeout_q, err_timeout_d;
  logic               pg_done_q, pg_done_d;
  logic [NPG_W-1:0]   pages_done_q, pages_done_d;
  logic [NPG_W-1:0]   npages_q, npages_d;
  logic               pg_req_q, pg_req_d;
  logic               pg_optype_q, pg_optype_d;
  logic [ADDR_W-1:0]  pg_req_addr_q, pg_req_addr_d;
  logic               go_pend_q, go_pend_d;
  logic               abort_pend_q, abort_pend_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               ack_s1_q, ack_s_q;
  logic [NPG_W-1:0]   pages_inc;

  // Bring the mux ack into the xdom clock domain through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      ack_s1_q <= pg_if.pg_ack;
      ack_s_q  <= ack_s1_q;
    end
  end

  // State and output registers; everything visible outside is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      pg_done_q     <= 1'b0;
      pages_done_q  <= '0;
      npages_q      <= '0;
      pg_req_q      <= 1'b0;
      pg_optype_q   <= 1'b0;
      pg_req_addr_q <= '0;
      go_pend_q     <= 1'b0;
      abort_pend_q  <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_timeout_q <= err_timeout_d;
      pg_done_q     <= pg_done_d;
      pages_done_q  <= pages_done_d;
      npages_q      <= npages_d;
      pg_req_q      <= pg_req_d;
      pg_optype_q   <= pg_optype_d;
      pg_req_addr_q <= pg_req_addr_d;
      go_pend_q     <= go_pend_d;
      abort_pend_q  <= abort_pend_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Next-state logic: per-page go pacing, handshake phases, abort at page boundary.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    err_timeout_d = err_timeout_q;
    pg_done_d     = 1'b0;
    pages_done_d  = pages_done_q;
    npages_d      = npages_q;
    pg_req_d      = pg_req_q;
    pg_optype_d   = pg_optype_q;
    pg_req_addr_d = pg_req_addr_q;
    // go and abort requests are remembered only while a sequence is running
    go_pend_d     = go_pend_q | (busy_q & buf_go);
    abort_pend_d  = abort_pend_q | (busy_q & cmd_abort);
    to_cnt_d      = to_cnt_q;
    pages_inc     = pages_done_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          pg_optype_d   = cmd_optype;
          pg_req_addr_d = cmd_addr;
          npages_d      = cmd_npages;
          pages_done_d  = '0;
          aborted_d     = 1'b0;
          err_timeout_d = 1'b0;
          go_pend_d     = 1'b0;
          abort_pend_d  = 1'b0;
          busy_d        = 1'b1;
          state_d       = (cmd_npages == '0) ? FIN : WAIT_GO;
        end
      end

      WAIT_GO: begin
        // Abort outranks a go arriving in the same cycle.
        if (abort_pend_q || cmd_abort) begin
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = FIN;
        end else if (go_pend_q || buf_go) begin
          pg_req_d  = 1'b1;
          go_pend_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = REQ;
        end
      end

      REQ: begin
        // The mux holds its grant once given, so the request is never withdrawn early.
        if (ack_s_q) begin
          pg_req_d = 1'b0;
          to_cnt_d = '0;
          state_d  = ACKLOW;
        end else if (to_cnt_q == TO_MAX) begin
          err_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ACKLOW: begin
        if (!ack_s_q) begin
          pg_done_d     = 1'b1;
          pages_done_d  = pages_inc;
          pg_req_addr_d = pg_req_addr_q + PG_STRIDE;
          state_d       = (pages_inc == npages_q) ? FIN : WAIT_GO;
        end else if (to_cnt_q == TO_MAX) begin
          err_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign aborted           = aborted_q;
  assign err_timeout       = err_timeout_q;
  assign pg_done           = pg_done_q;
  assign pages_done        = pages_done_q;
  assign pg_if.pg_req      = pg_req_q;
  assign pg_if.pg_optype   = pg_optype_q;
  assign pg_if.pg_req_addr = pg_req_addr_q;

endmodule

// File: tb/tb_xdom_ddr3_pg_requester.sv
// Self-checking bench for the xdom page requester: directed stimulus, scoreboard monitor.
// Expected page requests and sequence completions are queued by the stimulus.
// A negedge monitor pops and compares on each pg_req rise and each done pulse.
module tb_xdom_ddr3_pg_requester;

  localparam int ADDR_W = 28;
  localparam int NPG_W  = 8;
  localparam int TO_W   = 10;
  localparam int TO_MAX = (1 << TO_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0;
  logic              cmd_optype = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [NPG_W-1:0]  cmd_npages = '0;
  logic              cmd_abort = 1'b0;
  logic              buf_go = 1'b0;
  logic              busy, done, aborted, err_timeout, pg_done;
  logic [NPG_W-1:0]  pages_done;

  xdom_ddr3_pg_requester_if #(.ADDR_W(ADDR_W)) pg_if ();

  xdom_ddr3_pg_requester #(
    .ADDR_W    (ADDR_W),
    .PG_STRIDE (28'h400),
    .NPG_W     (NPG_W),
    .TO_W      (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_start   (cmd_start),
    .cmd_optype  (cmd_optype),
    .cmd_addr    (cmd_addr),
    .cmd_npages  (cmd_npages),
    .cmd_abort   (cmd_abort),
    .buf_go      (buf_go),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .err_timeout (err_timeout),
    .pg_done     (pg_done),
    .pages_done  (pages_done),
    .pg_if       (pg_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              op;
  } req_exp_t;

  typedef struct {
    logic [NPG_W-1:0] pages;
    logic             ab;
    logic             to;
  } done_exp_t;

  req_exp_t  exp_req_q[$];
  done_exp_t exp_done_q[$];
  req_exp_t  re;
  done_exp_t de;
  int        nchk = 0;
  int        nerr = 0;
  int        pg_cnt = 0;
  logic      prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each request rise and each completion against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      pg_cnt   = 0;
    end else begin
      if (pg_if.pg_req && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_pg_req: rose with addr 0x%0h, want no request at %0t",
                   pg_if.pg_req_addr, $time);
        end else begin
          re = exp_req_q.pop_front();
          chk("mon_req_addr", 32'(pg_if.pg_req_addr), 32'(re.addr));
          chk("mon_req_optype", 32'(pg_if.pg_optype), 32'(re.op));
        end
      end
      prev_req = pg_if.pg_req;
      if (pg_done) pg_cnt++;
      if (done) begin
        if (exp_done_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_done: done pulsed, want none at %0t", $time);
        end else begin
          de = exp_done_q.pop_front();
          chk("mon_pages_done", 32'(pages_done), 32'(de.pages));
          chk("mon_pg_done_cnt", 32'(pg_cnt), 32'(de.pages));
          chk("mon_aborted", 32'(aborted), 32'(de.ab));
          chk("mon_err_timeout", 32'(err_timeout), 32'(de.to));
          chk("mon_busy_at_done", 32'(busy), 32'h0);
        end
        pg_cnt = 0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic op, input logic [ADDR_W-1:0] addr, input logic [NPG_W-1:0] np);
    cmd_optype = op;
    cmd_addr   = addr;
    cmd_npages = np;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
  endtask

  task automatic expect_done(input logic [NPG_W-1:0] np, input logic ab, input logic to);
    done_exp_t d;
    d.pages = np;
    d.ab    = ab;
    d.to    = to;
    exp_done_q.push_back(d);
  endtask

  task automatic expect_req(input logic [ADDR_W-1:0] addr, input logic op);
    req_exp_t r;
    r.addr = addr;
    r.op   = op;
    exp_req_q.push_back(r);
  endtask

  // buf_go pulse in WAIT_GO: pg_req is high right after the sampling edge.
  task automatic page_go(input logic [ADDR_W-1:0] addr, input logic op);
    expect_req(addr, op);
    buf_go = 1'b1;
    tick();
    buf_go = 1'b0;
    chk("pg_req_rise", 32'(pg_if.pg_req), 32'h1);
    chk("pg_req_addr", 32'(pg_if.pg_req_addr), 32'(addr));
  endtask

  // Ack travels sync flop 1, sync flop 2, then the registered pg_req drops on the third edge.
  // Ack low follows the same path to the pg_done pulse.
  task automatic page_ack(input int delay);
    repeat (delay) tick();
    pg_if.pg_ack = 1'b1;
    tick();
    tick();
    chk("pg_req_hold", 32'(pg_if.pg_req), 32'h1);
    tick();
    chk("pg_req_fall", 32'(pg_if.pg_req), 32'h0);
    pg_if.pg_ack = 1'b0;
    tick();
    tick();
    chk("pg_done_early", 32'(pg_done), 32'h0);
    tick();
    chk("pg_done", 32'(pg_done), 32'h1);
  endtask

  initial begin
    pg_if.pg_ack = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_aborted", 32'(aborted), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);
    chk("rst_pg_done", 32'(pg_done), 32'h0);
    chk("rst_pages", 32'(pages_done), 32'h0);
    chk("rst_pg_req", 32'(pg_if.pg_req), 32'h0);
    chk("rst_addr", 32'(pg_if.pg_req_addr), 32'h0);
    rst = 1'b0;
    tick();

    // 1: single write page
    start_cmd(1'b0, 28'h0000100, 8'd1);
    expect_done(8'd1, 1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_req_before_go", 32'(pg_if.pg_req), 32'h0);
    page_go(28'h0000100, 1'b0);
    chk("t1_optype", 32'(pg_if.pg_optype), 32'h0);
    page_ack(10);
    chk("t1_pages", 32'(pages_done), 32'h1);
    chk("t1_done_early", 32'(done), 32'h0);
    tick();
    chk("t1_done", 32'(done), 32'h1);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_pages_hold", 32'(pages_done), 32'h1);

    // 2: three read pages, each paced by its own buf_go
    start_cmd(1'b1, 28'h0000000, 8'd3);
    expect_done(8'd3, 1'b0, 1'b0);
    repeat (4) tick();
    page_go(28'h0000000, 1'b1);
    page_ack(2);
    repeat (3) tick();
    chk("t2_idle_req", 32'(pg_if.pg_req), 32'h0);
    page_go(28'h0000400, 1'b1);
    page_ack(5);
    chk("t2_pages2", 32'(pages_done), 32'h2);
    page_go(28'h0000800, 1'b1);
    page_ack(1);
    tick();
    chk("t2_done", 32'(done), 32'h1);

    // 3: address wrap; second go arrives early during REQ and is held pending
    start_cmd(1'b0, 28'hFFFFC00, 8'd2);
    expect_done(8'd2, 1'b0, 1'b0);
    page_go(28'hFFFFC00, 1'b0);
    expect_req(28'h0000000, 1'b0);
    buf_go = 1'b1;
    tick();
    buf_go = 1'b0;
    page_ack(2);
    tick();
    chk("t3_pend_req", 32'(pg_if.pg_req), 32'h1);
    chk("t3_wrap_addr", 32'(pg_if.pg_req_addr), 32'h0);
    page_ack(2);
    tick();
    chk("t3_done", 32'(done), 32'h1);

    // 4a: abort during REQ of page 1 of 4
    start_cmd(1'b1, 28'h0002000, 8'd4);
    expect_done(8'd1, 1'b1, 1'b0);
    page_go(28'h0002000, 1'b1);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    page_ack(3);
    chk("t4_pages", 32'(pages_done), 32'h1);
    tick();
    chk("t4_aborted", 32'(aborted), 32'h1);
    tick();
    chk("t4_done", 32'(done), 32'h1);
    buf_go = 1'b1;
    tick();
    buf_go = 1'b0;
    repeat (5) tick();
    chk("t4_no_req", 32'(pg_if.pg_req), 32'h0);

    // 4b: abort and go in the same WAIT_GO cycle
    start_cmd(1'b0, 28'h0003000, 8'd2);
    expect_done(8'd0, 1'b1, 1'b0);
    chk("t4b_abort_clr", 32'(aborted), 32'h0);
    cmd_abort = 1'b1;
    buf_go    = 1'b1;
    tick();
    cmd_abort = 1'b0;
    buf_go    = 1'b0;
    chk("t4b_no_req", 32'(pg_if.pg_req), 32'h0);
    chk("t4b_aborted", 32'(aborted), 32'h1);
    tick();
    chk("t4b_done", 32'(done), 32'h1);

    // 5: ack withheld past timeout, start while busy ignored, late ack completes
    start_cmd(1'b0, 28'h0000500, 8'd1);
    expect_done(8'd1, 1'b0, 1'b1);
    page_go(28'h0000500, 1'b0);
    cmd_optype = 1'b1;
    cmd_addr   = 28'h0000AAA;
    cmd_npages = 8'd5;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
    repeat (TO_MAX - 1) tick();
    chk("t5_err_before", 32'(err_timeout), 32'h0);
    tick();
    chk("t5_err", 32'(err_timeout), 32'h1);
    chk("t5_req_held", 32'(pg_if.pg_req), 32'h1);
    chk("t5_optype", 32'(pg_if.pg_optype), 32'h0);
    chk("t5_addr", 32'(pg_if.pg_req_addr), 32'h500);
    page_ack(0);
    chk("t5_pages", 32'(pages_done), 32'h1);
    tick();
    chk("t5_done", 32'(done), 32'h1);

    // 5b: zero pages
    start_cmd(1'b0, 28'h0000700, 8'd0);
    expect_done(8'd0, 1'b0, 1'b0);
    chk("t5b_err_clr", 32'(err_timeout), 32'h0);
    chk("t5b_done_early", 32'(done), 32'h0);
    tick();
    chk("t5b_done", 32'(done), 32'h1);

    // 6: reset while pg_req is high with pages_done and err_timeout set
    start_cmd(1'b1, 28'h0000900, 8'd2);
    page_go(28'h0000900, 1'b1);
    page_ack(1);
    page_go(28'h0000D00, 1'b1);
    repeat (TO_MAX + 1) tick();
    chk("t6_pre_err", 32'(err_timeout), 32'h1);
    chk("t6_pre_pages", 32'(pages_done), 32'h1);
    rst = 1'b1;
    tick();
    chk("t6_pg_req", 32'(pg_if.pg_req), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_pages", 32'(pages_done), 32'h0);
    chk("t6_err", 32'(err_timeout), 32'h0);
    chk("t6_aborted", 32'(aborted), 32'h0);
    chk("t6_optype", 32'(pg_if.pg_optype), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_stay_idle", 32'(pg_if.pg_req), 32'h0);

    chk("left_req_exp", 32'(exp_req_q.size()), 32'h0);
    chk("left_done_exp", 32'(exp_done_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
